// File: rtl/parallelizer_scheduler.sv
// Round-robin scheduler that hands the shared serial-to-parallel converter to one of three
// requesters, shifts its packet in, waits for completion and presents it to the consumer.
module parallelizer_scheduler #(
   parameter int TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic [2:0] src_bit,
   output logic [2:0] grant,
   output logic [1:0] par_sel,
   output logic       par_shift_en,
   output logic       par_serial,
   input  logic       par_valid,
   output logic       out_valid,
   output logic [1:0] out_src,
   input  logic       out_ready,
   output logic       err_timeout,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT, HANDOFF} state_t;

   localparam int             WW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0]  WAIT_LAST  = WW'(TIMEOUT - 1);
   localparam logic [8:0]     LAST_TRIV  = 9'd159;
   localparam logic [8:0]     LAST_OTHER = 9'd383;

   state_t        state_q, state_d;
   logic [2:0]    grant_q, grant_d;
   logic [1:0]    par_sel_q, par_sel_d;
   logic [8:0]    bit_cnt_q, bit_cnt_d;
   logic [WW-1:0] wait_cnt_q, wait_cnt_d;
   logic [1:0]    last_q, last_d;
   logic          err_q, err_d;

   logic          pick_valid;
   logic [1:0]    pick_idx;
   logic [1:0]    cand;
   logic [8:0]    last_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= 3'b000;
         par_sel_q  <= 2'b00;
         bit_cnt_q  <= '0;
         wait_cnt_q <= '0;
         last_q     <= 2'd2;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         par_sel_q  <= par_sel_d;
         bit_cnt_q  <= bit_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         last_q     <= last_d;
         err_q      <= err_d;
      end
   end

   // Search from the requester after the last one served; lowest offset wins.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = 2'd0;
      cand       = 2'd0;
      for (int k = 3; k >= 1; k--) begin
         cand = 2'((int'(last_q) + k) % 3);
         if (req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      par_sel_d  = par_sel_q;
      bit_cnt_d  = bit_cnt_q;
      wait_cnt_d = wait_cnt_q;
      last_d     = last_q;
      err_d      = 1'b0;
      last_cnt   = (par_sel_q == 2'd1) ? LAST_TRIV : LAST_OTHER;
      unique case (state_q)
         IDLE: begin
            bit_cnt_d  = '0;
            wait_cnt_d = '0;
            grant_d    = 3'b000;
            par_sel_d  = 2'd0;
            if (pick_valid) begin
               state_d   = SHIFT;
               grant_d   = 3'b001 << pick_idx;
               par_sel_d = pick_idx;
            end
         end
         SHIFT: begin
            if (par_valid) begin
               state_d   = IDLE;
               err_d     = 1'b1;
               grant_d   = 3'b000;
               par_sel_d = 2'd0;
               last_d    = par_sel_q;
               bit_cnt_d = '0;
            end else if (bit_cnt_q == last_cnt) begin
               state_d    = WAIT;
               bit_cnt_d  = '0;
               wait_cnt_d = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + 9'd1;
            end
         end
         WAIT: begin
            if (par_valid) begin
               state_d = HANDOFF;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d    = IDLE;
               err_d      = 1'b1;
               grant_d    = 3'b000;
               par_sel_d  = 2'd0;
               last_d     = par_sel_q;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         HANDOFF: begin
            if (out_ready) begin
               state_d   = IDLE;
               grant_d   = 3'b000;
               par_sel_d = 2'd0;
               last_d    = par_sel_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant        = grant_q;
      par_sel      = par_sel_q;
      err_timeout  = err_q;
      busy         = (state_q != IDLE);
      par_shift_en = (state_q == SHIFT);
      out_valid    = (state_q == HANDOFF);
      out_src      = (state_q == HANDOFF) ? par_sel_q : 2'd0;
      par_serial   = 1'b0;
      if (state_q == SHIFT) begin
         case (par_sel_q)
            2'd0:    par_serial = src_bit[0];
            2'd1:    par_serial = src_bit[1];
            2'd2:    par_serial = src_bit[2];
            default: par_serial = 1'b0;
         endcase
      end
   end

endmodule
